// File: rtl/euler_result_drain_pkg.sv
// Shared types and constants for the Euler result-RAM drain engine.
package euler_result_drain_pkg;

   localparam int ADD_SIZE_DEF  = 16;
   localparam int DATA_SIZE_DEF = 16;

   localparam int FIFO_DEPTH = 2;
   localparam int FIFO_CNT_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/euler_result_drain_result_skid_fifo.sv
// Two-entry FIFO that absorbs the RAM read latency; entry 0 is always the head.
module result_skid_fifo
   import euler_result_drain_pkg::*;
#(
   parameter int DATA_SIZE = DATA_SIZE_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_SIZE-1:0]  din,
   input  logic                  pop,
   output logic [DATA_SIZE-1:0]  dout,
   output logic                  valid,
   output logic [FIFO_CNT_W-1:0] cnt
);

   logic [DATA_SIZE-1:0] entry_reg [0:FIFO_DEPTH-1];
   logic [FIFO_CNT_W-1:0] cnt_reg;

   assign dout  = entry_reg[0];
   assign valid = (cnt_reg != '0);
   assign cnt   = cnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) entry_reg[i] <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (cnt_reg < FIFO_CNT_W'(FIFO_DEPTH)) begin
                  entry_reg[cnt_reg[0]] <= din;
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            2'b01: begin
               entry_reg[0] <= entry_reg[1];
               cnt_reg      <= cnt_reg - 1'b1;
            end
            2'b11: begin
               // Pop and push together: occupancy unchanged, new word lands behind the survivor.
               if (cnt_reg == FIFO_CNT_W'(1)) begin
                  entry_reg[0] <= din;
               end else begin
                  entry_reg[0] <= entry_reg[1];
                  entry_reg[1] <= din;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/euler_result_drain.sv
// Reads a programmable range of the result RAM and streams it out over valid/ready.
module euler_result_drain
   import euler_result_drain_pkg::*;
#(
   parameter int ADD_SIZE  = ADD_SIZE_DEF,
   parameter int DATA_SIZE = DATA_SIZE_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ADD_SIZE-1:0]  base_addr,
   input  logic [ADD_SIZE-1:0]  count,
   output logic                 ram_rd_en,
   output logic [ADD_SIZE-1:0]  ram_addr,
   input  logic [DATA_SIZE-1:0] ram_data,
   output logic [DATA_SIZE-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last,
   output logic                 busy,
   output logic                 done
);

   state_t                state_reg;
   logic [ADD_SIZE-1:0]   count_reg;
   logic [ADD_SIZE-1:0]   rd_addr_reg;
   logic [ADD_SIZE-1:0]   issued_reg;
   logic [ADD_SIZE-1:0]   sent_reg;
   logic                  inflight_reg;
   logic [FIFO_CNT_W-1:0] fifo_cnt;
   logic                  pop;
   logic [2:0]            occ_next;

   assign pop = out_valid && out_ready;
   // Occupancy after this edge if nothing new is issued; a fresh issue must still fit.
   assign occ_next  = {1'b0, fifo_cnt} + {2'b00, inflight_reg} - {2'b00, pop};
   assign ram_rd_en = (state_reg == ST_READ) && (issued_reg < count_reg) && (occ_next < 3'd2);
   assign ram_addr  = rd_addr_reg;
   assign out_last  = out_valid && (sent_reg == count_reg - ADD_SIZE'(1));
   assign busy      = (state_reg != ST_IDLE);
   assign done      = (state_reg == ST_DONE);

   result_skid_fifo #(.DATA_SIZE(DATA_SIZE)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (inflight_reg),
      .din   (ram_data),
      .pop   (pop),
      .dout  (out_data),
      .valid (out_valid),
      .cnt   (fifo_cnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         count_reg    <= '0;
         rd_addr_reg  <= '0;
         issued_reg   <= '0;
         sent_reg     <= '0;
         inflight_reg <= 1'b0;
      end else begin
         inflight_reg <= ram_rd_en;
         if (ram_rd_en) begin
            rd_addr_reg <= rd_addr_reg + 1'b1;
            issued_reg  <= issued_reg + 1'b1;
         end
         if (pop) sent_reg <= sent_reg + 1'b1;

         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  count_reg   <= count;
                  rd_addr_reg <= base_addr;
                  issued_reg  <= '0;
                  sent_reg    <= '0;
                  state_reg   <= (count == '0) ? ST_DONE : ST_READ;
               end
            end
            ST_READ: begin
               if (pop && out_last)              state_reg <= ST_DONE;
               else if (issued_reg == count_reg) state_reg <= ST_FLUSH;
            end
            ST_FLUSH: begin
               if (pop && out_last) state_reg <= ST_DONE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_euler_result_drain.sv
// Scoreboard bench for euler_result_drain with a behavioural one-cycle-latency RAM.
module tb_euler_result_drain;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] base_addr = '0;
   logic [15:0] count = '0;
   logic        ram_rd_en;
   logic [15:0] ram_addr;
   logic [15:0] ram_data = '0;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_last;
   logic        busy;
   logic        done;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   euler_result_drain #(.ADD_SIZE(16), .DATA_SIZE(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .count     (count),
      .ram_rd_en (ram_rd_en),
      .ram_addr  (ram_addr),
      .ram_data  (ram_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   // RAM content: 0x0100 + (addr - 0x10), wrapping
   function automatic logic [15:0] ram_val(input logic [15:0] a);
      return a + 16'h00F0;
   endfunction

   always @(posedge clk) if (ram_rd_en) ram_data <= ram_val(ram_addr);

   function automatic logic rdy(input int mode, input int cyc);
      logic [5:0] pat;
      pat = 6'b101001; // bit k = ready in cycle k of the repeating 1,0,0,1,0,1 sequence
      if (mode == 0) return 1'b1;
      return pat[cyc % 6];
   endfunction

   task automatic run_xfer(input logic [15:0] b, input logic [15:0] n, input int mode,
                           input bit second_start, input int exp_done_cyc);
      logic [15:0] exp_q[$];
      logic [15:0] next_addr, exp_w, prev_data;
      logic        prev_last;
      int reads, hs, first_valid;
      bit got_done, prev_stall, last_hs_prev;
      next_addr = b; reads = 0; hs = 0; first_valid = -1;
      got_done = 0; prev_stall = 0; last_hs_prev = 0; prev_data = '0; prev_last = 0;
      for (int i = 0; i < int'(n); i++) exp_q.push_back(ram_val(b + 16'(i)));

      @(negedge clk);
      base_addr = b; count = n; start = 1'b1; out_ready = rdy(mode, 0);
      #1;
      n_cmp++;
      if (busy !== 1'b0 || ram_rd_en !== 1'b0) begin
         n_bad++; $display("FAIL idle_before_start busy=%b rd_en=%b required 0/0", busy, ram_rd_en);
      end

      for (int cyc = 1; cyc < 300 && !got_done; cyc++) begin
         @(negedge clk);
         if (second_start && cyc == 4) begin
            start = 1'b1; base_addr = b + 16'h0100; count = n + 16'd2;
         end else begin
            start = 1'b0; base_addr = b; count = n;
         end
         out_ready = rdy(mode, cyc);
         #1;
         n_cmp++;
         if (reads - hs > 2) begin
            n_bad++; $display("FAIL buffered_words got=%0d required<=2", reads - hs);
         end
         if (prev_stall) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
               n_bad++;
               $display("FAIL stall_hold valid=%b data=%h last=%b required 1/%h/%b",
                        out_valid, out_data, out_last, prev_data, prev_last);
            end
         end
         if (ram_rd_en === 1'b1) begin
            n_cmp++;
            if (ram_addr !== next_addr || reads >= int'(n)) begin
               n_bad++;
               $display("FAIL read_addr got=%h required=%h (read %0d of %0d)", ram_addr, next_addr, reads, n);
            end
            next_addr = next_addr + 16'd1;
            reads++;
         end
         if (out_valid === 1'b1 && first_valid < 0) first_valid = cyc;
         if (done === 1'b1) begin
            got_done = 1;
            n_cmp++;
            if ((n != 0 && !last_hs_prev) || hs != int'(n)) begin
               n_bad++;
               $display("FAIL done_timing got hs=%0d after_last=%b required hs=%0d after_last=1", hs, last_hs_prev, n);
            end
            if (exp_done_cyc >= 0) begin
               n_cmp++;
               if (cyc != exp_done_cyc) begin
                  n_bad++; $display("FAIL done_cycle got=%0d required=%0d", cyc, exp_done_cyc);
               end
            end
         end
         last_hs_prev = 0;
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++; $display("FAIL extra_word got=%h required none", out_data);
            end else begin
               exp_w = exp_q.pop_front();
               if (out_data !== exp_w || out_last !== (exp_q.size() == 0)) begin
                  n_bad++;
                  $display("FAIL word got=%h last=%b required=%h last=%b",
                           out_data, out_last, exp_w, exp_q.size() == 0);
               end
            end
            hs++;
            $display("word %0d data=%h last=%b cyc=%0d", hs, out_data, out_last, cyc);
            if (hs == int'(n)) last_hs_prev = 1;
         end
         prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
         prev_data  = out_data;
         prev_last  = out_last;
      end
      start = 1'b0;

      n_cmp++;
      if (!got_done) begin
         n_bad++; $display("FAIL done_timeout got no done required done within 300 cycles");
      end
      n_cmp++;
      if (exp_q.size() != 0 || reads != int'(n)) begin
         n_bad++; $display("FAIL word_count left=%0d reads=%0d required left=0 reads=%0d", exp_q.size(), reads, n);
      end
      n_cmp++;
      if (n == 0 ? (first_valid != -1) : (mode == 0 && first_valid != 3)) begin
         n_bad++; $display("FAIL first_valid got cyc=%0d required %0d", first_valid, (n == 0) ? -1 : 3);
      end
      @(negedge clk); #1;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_bad++; $display("FAIL back_to_idle busy=%b done=%b required 0/0", busy, done);
      end
      $display("xfer base=%h count=%0d mode=%0d words=%0d", b, n, mode, hs);
   endtask

   task automatic check_all_zero(input string tag);
      n_cmp++;
      if ({ram_rd_en, ram_addr, out_valid, out_last, out_data, busy, done} !== '0) begin
         n_bad++;
         $display("FAIL %s rd_en=%b addr=%h valid=%b last=%b data=%h busy=%b done=%b required all 0",
                  tag, ram_rd_en, ram_addr, out_valid, out_last, out_data, busy, done);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1 check_all_zero("reset_state");
      @(negedge clk); rst = 1'b0;
      @(negedge clk); #1 check_all_zero("idle_after_reset");
   endtask

   task automatic test_basic_stream();
      run_xfer(16'h0010, 16'd6, 0, 0, 9);
   endtask

   task automatic test_backpressure();
      run_xfer(16'h0010, 16'd6, 1, 0, -1);
   endtask

   task automatic test_addr_wrap();
      run_xfer(16'hFFFE, 16'd4, 0, 0, 7);
   endtask

   task automatic test_zero_and_ignored_start();
      run_xfer(16'h0020, 16'd0, 0, 0, 1);
      run_xfer(16'h0010, 16'd6, 0, 1, 9);
   endtask

   task automatic test_reset_mid();
      int hs;
      hs = 0;
      @(negedge clk);
      base_addr = 16'h0010; count = 16'd6; start = 1'b1; out_ready = 1'b1;
      for (int cyc = 1; cyc < 50 && hs < 3; cyc++) begin
         @(negedge clk); start = 1'b0; #1;
         if (out_valid === 1'b1 && out_ready === 1'b1) hs++;
      end
      n_cmp++;
      if (hs != 3) begin
         n_bad++; $display("FAIL reset_mid_handshakes got=%0d required=3", hs);
      end
      @(posedge clk); #3;
      rst = 1'b1;
      #1 check_all_zero("async_reset_mid");
      @(negedge clk); rst = 1'b0;
      run_xfer(16'h0010, 16'd6, 0, 0, 9);
   endtask

   initial begin
      test_reset();
      test_basic_stream();
      test_backpressure();
      test_addr_wrap();
      test_zero_and_ignored_start();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
